// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic [1:0]       stage_s;
    logic             d_s;
    logic             brw_next_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // One full-subtractor stage: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        full_sub = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
    endfunction

    // Current bit of the serial stage.
    always_comb begin
        stage_s    = full_sub(a_sh[0], b_sh[0], brw);
        d_s        = stage_s[0];
        brw_next_s = stage_s[1];
    end

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= {WIDTH{1'b0}};
            b_sh  <= {WIDTH{1'b0}};
            r_sh  <= {WIDTH{1'b0}};
            brw   <= 1'b0;
            cnt   <= {CW{1'b0}};
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= {WIDTH{1'b0}};
            bout  <= 1'b0;
            ovf   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= 1'b0;
                        cnt   <= {CW{1'b0}};
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    brw  <= brw_next_s;
                    r_sh <= {d_s, r_sh[WIDTH-1:1]};
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    // Last bit: d_s is the result MSB, brw_next_s the final borrow.
                    if (cnt == CNT_LAST) begin
                        diff  <= {d_s, r_sh[WIDTH-1:1]};
                        bout  <= brw_next_s;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb != b_msb) && (d_s != a_msb);
`else
                        ovf   <= 1'b0;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= SHIFT;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); honours SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int n_vec;
    int n_bad;
    logic [9:0] exp_q[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {ovf, bout, diff}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] r;
        logic       o;
        r = {1'b0, x} - {1'b0, y};
`ifdef SERIAL_SUB_OVF_EN
        o = (x[7] != y[7]) && (r[7] != x[7]);
`else
        o = 1'b0;
`endif
        return {o, r};
    endfunction

    // Result monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            check_eq("busy_with_done", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check_eq("diff", {24'd0, diff}, {24'd0, e[7:0]});
                check_eq("bout", {31'd0, bout}, {31'd0, e[8]});
                check_eq("ovf",  {31'd0, ovf},  {31'd0, e[9]});
            end
        end
    end

    task automatic start_op(input logic [7:0] x, input logic [7:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(x, y));
        #1 start = 1'b0;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
    endtask

    // Returns at the negedge where done is seen, so a following start_op is back-to-back.
    task automatic wait_done(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_diff", {24'd0, diff}, 32'd0);
        check_eq("rst_bout", {31'd0, bout}, 32'd0);
        check_eq("rst_ovf",  {31'd0, ovf},  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: 8 busy cycles, done in cycle 9 after the start edge
        start_op(8'h05, 8'h02);
        busy_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 12 && done_at == 0; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_at = i;
        end
        check_eq("busy_cycles", busy_cnt, 32'd8);
        check_eq("done_cycle", done_at, 32'd9);
        @(negedge clk);
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);

        // Borrow cases
        start_op(8'h02, 8'h05);
        wait_done(20);
        start_op(8'h00, 8'h01);
        wait_done(20);
        start_op(8'h00, 8'hFF);
        wait_done(20);

        // start during SHIFT is ignored, start during DONE chains immediately
        start_op(8'h33, 8'h12);
        repeat (3) @(posedge clk);
        #1 a = 8'hAA; b = 8'h11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq("shift_busy", {31'd0, busy}, 32'd1);
        wait_done(20);
        start_op(8'h40, 8'h41);
        @(negedge clk);
        check_eq("b2b_busy", {31'd0, busy}, 32'd1);
        check_eq("b2b_done", {31'd0, done}, 32'd0);
        wait_done(20);

        // Reset mid-operation aborts with no done
        @(posedge clk);
        #1;
        start_op(8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_diff", {24'd0, diff}, 32'd0);
        check_eq("abort_bout", {31'd0, bout}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        start_op(8'h7F, 8'h7F);
        wait_done(20);

        // Signed overflow vectors
        start_op(8'h80, 8'h01);
        wait_done(20);
        start_op(8'h7F, 8'hFF);
        wait_done(20);
        start_op(8'h05, 8'h02);
        wait_done(20);

        // Random back-to-back operations
        for (int k = 0; k < 1000; k++) begin
            start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_done(20);
        end

        repeat (3) @(posedge clk);
        check_eq("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
